mdc_butterfly_stage: RTL and testbench



---
 rtl/mdc_butterfly_stage.sv | 198 +++++++++++++++++++
 tb/tb_mdc_butterfly_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_butterfly_stage.sv
// Radix-2 DIF butterfly with twiddle multiply for one MDC FFT stage.
// Fixed 3-cycle latency: sum/difference, complex multiply, round/saturate.
module mdc_butterfly_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 8,
   parameter int STAGE      = 0,
   parameter int TW_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      in_sop,
   input  logic [DATA_WIDTH-1:0]     x0,
   input  logic [DATA_WIDTH-1:0]     x1,
   output logic [$clog2(N/2)-1:0]    tw_addr,
   input  logic [2*TW_WIDTH-1:0]     tw_data,
   output logic [DATA_WIDTH-1:0]     y0,
   output logic [DATA_WIDTH-1:0]     y1,
   output logic                      out_valid,
   output logic                      out_sop
);

   localparam int H  = DATA_WIDTH / 2;
   localparam int AW = $clog2(N / 2);
   localparam int P  = H + TW_WIDTH + 1;
   localparam int M  = N >> (STAGE + 1);
   localparam logic [AW-1:0] IDX_MASK = AW'(M - 1);
   localparam logic [AW-1:0] CNT_LAST = AW'(N / 2 - 1);
   localparam logic signed [P-1:0] SAT_MAX = P'((1 << (H - 1)) - 1);
   localparam logic signed [P-1:0] SAT_MIN = ~SAT_MAX;

   // ------------------------------------------------------------------
   // Pair counter and twiddle address
   // ------------------------------------------------------------------
   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;
   logic [AW-1:0] eff_idx;

   always_comb begin
      eff_idx = cnt_q;
      cnt_d   = cnt_q;
      if (in_valid) begin
         if (in_sop) begin
            eff_idx = '0;
            cnt_d   = AW'(1);
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The stride of later stages folds the index onto a coarser twiddle grid.
   assign tw_addr = (eff_idx & IDX_MASK) << STAGE;

   // ------------------------------------------------------------------
   // S1: halved sum and difference per component (1 = real, 0 = imag)
   // ------------------------------------------------------------------
   logic [1:0][H-1:0] s1_s_d;
   logic [1:0][H-1:0] s1_d_d;
   logic [1:0][H-1:0] s1_s_q;
   logic [1:0][H-1:0] s1_d_q;
   logic              s1_valid_q;
   logic              s1_sop_q;
   logic              s1_bypass_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_s1
      logic signed [H:0] a_ext;
      logic signed [H:0] b_ext;
      logic signed [H:0] sum_w;
      logic signed [H:0] dif_w;

      assign a_ext = {x0[gi*H+H-1], x0[gi*H +: H]};
      assign b_ext = {x1[gi*H+H-1], x1[gi*H +: H]};
      assign sum_w = a_ext + b_ext;
      assign dif_w = a_ext - b_ext;
      assign s1_s_d[gi] = H'(sum_w >>> 1);
      assign s1_d_d[gi] = H'(dif_w >>> 1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         s1_sop_q    <= 1'b0;
         s1_bypass_q <= 1'b0;
         s1_s_q      <= '0;
         s1_d_q      <= '0;
      end else begin
         s1_valid_q <= in_valid;
         s1_sop_q   <= in_valid & in_sop;
         if (in_valid) begin
            s1_s_q      <= s1_s_d;
            s1_d_q      <= s1_d_d;
            s1_bypass_q <= (tw_addr == '0);
         end
      end
   end

   // ------------------------------------------------------------------
   // S2: full-precision complex multiply with the ROM word
   // ------------------------------------------------------------------
   logic signed [TW_WIDTH-1:0] wr;
   logic signed [TW_WIDTH-1:0] wi;
   logic signed [P-1:0]        dr_x;
   logic signed [P-1:0]        di_x;
   logic signed [P-1:0]        wr_x;
   logic signed [P-1:0]        wi_x;
   logic [1:0][P-1:0]          prod_d;
   logic [1:0][P-1:0]          prod_q;
   logic [1:0][H-1:0]          s2_s_q;
   logic [1:0][H-1:0]          s2_d_q;
   logic                       s2_valid_q;
   logic                       s2_sop_q;
   logic                       s2_bypass_q;

   assign wr   = tw_data[2*TW_WIDTH-1:TW_WIDTH];
   assign wi   = tw_data[TW_WIDTH-1:0];
   assign dr_x = P'($signed(s1_d_q[1]));
   assign di_x = P'($signed(s1_d_q[0]));
   assign wr_x = P'(wr);
   assign wi_x = P'(wi);

   assign prod_d[1] = dr_x * wr_x - di_x * wi_x;
   assign prod_d[0] = dr_x * wi_x + di_x * wr_x;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid_q  <= 1'b0;
         s2_sop_q    <= 1'b0;
         s2_bypass_q <= 1'b0;
         s2_s_q      <= '0;
         s2_d_q      <= '0;
         prod_q      <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_sop_q   <= s1_sop_q;
         if (s1_valid_q) begin
            s2_bypass_q <= s1_bypass_q;
            s2_s_q      <= s1_s_q;
            s2_d_q      <= s1_d_q;
            prod_q      <= prod_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output: drop Q-format fraction (floor) and clamp to sample range
   // ------------------------------------------------------------------
   logic [1:0][H-1:0]      sat_w;
   logic [DATA_WIDTH-1:0]  y1_d;
   logic [DATA_WIDTH-1:0]  y0_q;
   logic [DATA_WIDTH-1:0]  y1_q;
   logic                   out_valid_q;
   logic                   out_sop_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_sat
      logic signed [P-1:0] sh_w;

      assign sh_w = $signed(prod_q[gi]) >>> (TW_WIDTH - 1);
      assign sat_w[gi] = (sh_w > SAT_MAX) ? SAT_MAX[H-1:0] :
                         (sh_w < SAT_MIN) ? SAT_MIN[H-1:0] :
                                            sh_w[H-1:0];
   end

   // W = 1 skips the multiplier so index 0 stays exact.
   assign y1_d = s2_bypass_q ? s2_d_q : sat_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y0_q        <= '0;
         y1_q        <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
      end else begin
         out_valid_q <= s2_valid_q;
         out_sop_q   <= s2_valid_q & s2_sop_q;
         if (s2_valid_q) begin
            y0_q <= s2_s_q;
            y1_q <= y1_d;
         end
      end
   end

   assign y0        = y0_q;
   assign y1        = y1_q;
   assign out_valid = out_valid_q;
   assign out_sop   = out_sop_q;

endmodule

// File: tb/tb_mdc_butterfly_stage.sv
// Bench for mdc_butterfly_stage: N=8 at STAGE 0,1,2 side by side, checked
// cycle by cycle against an arithmetic reference model of the butterfly.
module tb_mdc_butterfly_stage;

   localparam int NS = 3;

   typedef struct packed {
      logic                 v;
      logic                 sop;
      logic [NS-1:0][15:0]  y0;
      logic [NS-1:0][15:0]  y1;
   } exp_t;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sop   = 1'b0;
   logic [15:0] x0       = '0;
   logic [15:0] x1       = '0;

   logic [1:0]  tw_addr_w [NS];
   logic [31:0] tw_q      [NS];
   logic [15:0] y0_w      [NS];
   logic [15:0] y1_w      [NS];
   logic        ov_w      [NS];
   logic        os_w      [NS];

   logic [31:0] rom [4];

   exp_t                pipe[$];
   logic [NS-1:0][15:0] last_y0;
   logic [NS-1:0][15:0] last_y1;
   int                  cnt_m;
   int                  n_checks = 0;
   int                  n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NS; gi++) begin : g_dut
      mdc_butterfly_stage #(
         .DATA_WIDTH (16),
         .N          (8),
         .STAGE      (gi),
         .TW_WIDTH   (16)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid),
         .in_sop    (in_sop),
         .x0        (x0),
         .x1        (x1),
         .tw_addr   (tw_addr_w[gi]),
         .tw_data   (tw_q[gi]),
         .y0        (y0_w[gi]),
         .y1        (y1_w[gi]),
         .out_valid (ov_w[gi]),
         .out_sop   (os_w[gi])
      );

      always @(posedge clk) tw_q[gi] <= rom[tw_addr_w[gi]];
   end

   // ------------------------------------------------------------------
   // Reference arithmetic
   // ------------------------------------------------------------------
   function automatic longint re_of(input logic [15:0] v);
      logic signed [7:0] c;
      c = v[15:8];
      return longint'(c);
   endfunction

   function automatic longint im_of(input logic [15:0] v);
      logic signed [7:0] c;
      c = v[7:0];
      return longint'(c);
   endfunction

   function automatic longint fdiv(input longint v, input longint d);
      longint q;
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic longint clamp8(input longint v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic logic [15:0] pack(input longint re, input longint im);
      logic [7:0] r8;
      logic [7:0] i8;
      r8 = re[7:0];
      i8 = im[7:0];
      return {r8, i8};
   endfunction

   function automatic logic [15:0] model_y0(input logic [15:0] a, input logic [15:0] b);
      return pack(fdiv(re_of(a) + re_of(b), 2), fdiv(im_of(a) + im_of(b), 2));
   endfunction

   function automatic logic [15:0] model_y1(input logic [15:0] a, input logic [15:0] b,
                                            input int addr);
      longint dr, di, wr, wi;
      logic signed [15:0] w16;
      dr = fdiv(re_of(a) - re_of(b), 2);
      di = fdiv(im_of(a) - im_of(b), 2);
      if (addr == 0) return pack(dr, di);
      w16 = rom[addr][31:16];
      wr  = longint'(w16);
      w16 = rom[addr][15:0];
      wi  = longint'(w16);
      return pack(clamp8(fdiv(dr * wr - di * wi, 32768)),
                  clamp8(fdiv(dr * wi + di * wr, 32768)));
   endfunction

   function automatic logic [15:0] cplx(input int re, input int im);
      return pack(longint'(re), longint'(im));
   endfunction

   function automatic logic [7:0] rand_comp();
      case ($urandom_range(0, 7))
         0:       return 8'h7f;
         1:       return 8'h80;
         default: return 8'($urandom);
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   task automatic check_outputs();
      exp_t cur;
      cur = '0;
      if (pipe.size() == 3) cur = pipe.pop_front();
      if (cur.v) begin
         last_y0 = cur.y0;
         last_y1 = cur.y1;
         $display("out t=%0t sop=%0b y0=%h/%h/%h y1=%h/%h/%h", $time, cur.sop,
                  y0_w[0], y0_w[1], y0_w[2], y1_w[0], y1_w[1], y1_w[2]);
      end
      for (int s = 0; s < NS; s++) begin
         check_eq($sformatf("out_valid[s%0d]", s), 32'(ov_w[s]), 32'(cur.v));
         check_eq($sformatf("out_sop[s%0d]", s), 32'(os_w[s]), 32'(cur.v & cur.sop));
         check_eq($sformatf("y0[s%0d]", s), 32'(y0_w[s]), 32'(last_y0[s]));
         check_eq($sformatf("y1[s%0d]", s), 32'(y1_w[s]), 32'(last_y1[s]));
      end
   endtask

   // One clock cycle: check what leaves, present one input slot, predict it.
   task automatic step(input bit v, input bit sop, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   idx;
      int   addr;
      @(negedge clk);
      check_outputs();
      in_valid = v;
      in_sop   = sop;
      x0       = a;
      x1       = b;
      #1;
      e     = '0;
      e.v   = v;
      e.sop = v & sop;
      if (v) begin
         idx   = sop ? 0 : cnt_m;
         cnt_m = sop ? 1 : (cnt_m + 1) % 4;
         for (int s = 0; s < NS; s++) begin
            addr = (idx % (8 >> (s + 1))) << s;
            check_eq($sformatf("tw_addr[s%0d]", s), 32'(tw_addr_w[s]), 32'(addr));
            e.y0[s] = model_y0(a, b);
            e.y1[s] = model_y1(a, b, addr);
         end
      end
      pipe.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      #1;
      for (int s = 0; s < NS; s++) begin
         check_eq($sformatf("rst_y0[s%0d]", s), 32'(y0_w[s]), 32'h0);
         check_eq($sformatf("rst_y1[s%0d]", s), 32'(y1_w[s]), 32'h0);
         check_eq($sformatf("rst_valid[s%0d]", s), 32'(ov_w[s]), 32'h0);
         check_eq($sformatf("rst_sop[s%0d]", s), 32'(os_w[s]), 32'h0);
      end
      pipe.delete();
      last_y0 = '0;
      last_y1 = '0;
      cnt_m   = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   logic [1:0] addr_tbl [NS][8];
   logic [15:0] xa [3];
   logic [15:0] xb [3];

   initial begin
      addr_tbl = '{'{0, 1, 2, 3, 0, 1, 2, 3},
                   '{0, 2, 0, 2, 0, 2, 0, 2},
                   '{0, 0, 0, 0, 0, 0, 0, 0}};
      xa = '{cplx(10, 4), cplx(127, -128), cplx(10, 4)};
      xb = '{cplx(6, -2), cplx(-128, 127), cplx(6, -2)};
      rom[0] = 32'h1234_5678;
      rom[1] = 32'h8000_8000;
      rom[2] = 32'h0000_8000;
      rom[3] = 32'h5a82_a57e;
      last_y0 = '0;
      last_y1 = '0;
      cnt_m   = 0;

      apply_reset();

      // bypass, saturation (e=1), -j (e=2), then the rest of an 8-pair run
      for (int i = 0; i < 8; i++) begin
         if (i < 3) step(1'b1, i == 0, xa[i], xb[i]);
         else       step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
         for (int s = 0; s < NS; s++)
            check_eq($sformatf("seq_addr[s%0d][%0d]", s, i), 32'(tw_addr_w[s]),
                     32'(addr_tbl[s][i]));
      end
      idle(3);

      // bubbles, stray in_sop on a bubble, then an in_sop mid-frame
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
      step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      idle(4);

      // reset with pairs in flight; counter must restart at zero
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      idle(4);

      // randomized traffic with fresh ROM contents
      for (int a = 0; a < 4; a++) rom[a] = $urandom;
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
              {rand_comp(), rand_comp()}, {rand_comp(), rand_comp()});
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
